// File: rtl/grip_sequencer.sv
// Grip sequencer: closes N fingers until each tenzo limit trips, holds, then opens.
// Optional limit debounce is built when GRIP_DEBOUNCE_EN is defined.
module grip_sequencer #(
    parameter int N_FINGERS    = 5,
    parameter int TIMEOUT_CYC  = 1000,
    parameter int RELEASE_CYC  = 500,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_release,
    input  logic [N_FINGERS-1:0] i_limit,
    output logic [N_FINGERS-1:0] o_motor_close,
    output logic                 o_motor_open,
    output logic                 o_holding,
    output logic                 o_fault,
    output logic                 o_done,
    output logic [2:0]           o_state
);
    localparam int MAX_CYC = (TIMEOUT_CYC > RELEASE_CYC) ? TIMEOUT_CYC : RELEASE_CYC;
    localparam int TW = $clog2(MAX_CYC) + 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] RELEASE_LAST = TW'(RELEASE_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLOSE = 3'd1,
        ST_HOLD  = 3'd2,
        ST_OPEN  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [N_FINGERS-1:0]   lat_q, lat_d;
    logic [N_FINGERS-1:0]   acc;
    logic [TW-1:0]          timer_q, timer_d;
    logic [N_FINGERS-1:0]   motor_close_q, motor_close_d;
    logic                   motor_open_q, motor_open_d;
    logic                   holding_q, holding_d;
    logic                   fault_q, fault_d;
    logic                   done_q, done_d;

`ifdef GRIP_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [CW-1:0] RUN_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [N_FINGERS-1:0][CW-1:0] run_q, run_d;

    // Run counters saturate at DEBOUNCE_CYC-1; the next high sample is the accepting one.
    always_comb begin
        run_d = run_q;
        acc   = '0;
        for (int k = 0; k < N_FINGERS; k++) begin
            if (state_q == ST_IDLE && i_start) begin
                run_d[k] = '0;
            end else if (state_q == ST_CLOSE) begin
                if (i_limit[k]) begin
                    acc[k] = (run_q[k] == RUN_LAST);
                    if (run_q[k] != RUN_LAST) run_d[k] = run_q[k] + 1'b1;
                end else begin
                    run_d[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) run_q <= '0;
        else          run_q <= run_d;
    end
`else
    always_comb begin
        acc = (state_q == ST_CLOSE) ? i_limit : '0;
    end
`endif

    // State register; outputs are registered alongside it from next-state values.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            lat_q         <= '0;
            timer_q       <= '0;
            motor_close_q <= '0;
            motor_open_q  <= 1'b0;
            holding_q     <= 1'b0;
            fault_q       <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            lat_q         <= lat_d;
            timer_q       <= timer_d;
            motor_close_q <= motor_close_d;
            motor_open_q  <= motor_open_d;
            holding_q     <= holding_d;
            fault_q       <= fault_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_CLOSE;
                    lat_d   = '0;
                    timer_d = '0;
                end
            end
            ST_CLOSE: begin
                lat_d   = lat_q | acc;
                timer_d = timer_q + 1'b1;
                // Release beats completion, completion beats timeout.
                if (i_release) begin
                    state_d = ST_OPEN;
                    timer_d = '0;
                end else if (&lat_d) begin
                    state_d = ST_HOLD;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = ST_FAULT;
                end
            end
            ST_HOLD, ST_FAULT: begin
                if (i_release) begin
                    state_d = ST_OPEN;
                    timer_d = '0;
                end
            end
            ST_OPEN: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == RELEASE_LAST) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        motor_close_d = (state_d == ST_CLOSE) ? ~lat_d : '0;
        motor_open_d  = (state_d == ST_OPEN);
        holding_d     = (state_d == ST_HOLD);
        fault_d       = (state_d == ST_FAULT);
        done_d        = (state_q == ST_OPEN) && (state_d == ST_IDLE);
    end

    assign o_motor_close = motor_close_q;
    assign o_motor_open  = motor_open_q;
    assign o_holding     = holding_q;
    assign o_fault       = fault_q;
    assign o_done        = done_q;
    assign o_state       = state_q;
endmodule
